// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS subset core with on-chip instruction memory,
// data memory and register file; only clock and reset come from outside.

module mips_registers (
  input  logic        clock,
  input  logic [4:0]  ra1_s,
  input  logic [4:0]  ra2_s,
  output logic [31:0] rd1_s,
  output logic [31:0] rd2_s,
  input  logic        we_s,
  input  logic [4:0]  wa_s,
  input  logic [31:0] wd_s
);
  logic [31:0] data [0:31];

  assign rd1_s = (ra1_s == 5'd0) ? 32'd0 : data[ra1_s];
  assign rd2_s = (ra2_s == 5'd0) ? 32'd0 : data[ra2_s];

  // Write port; $0 stays hard-wired to zero
  always_ff @(posedge clock) begin
    if (we_s && (wa_s != 5'd0)) data[wa_s] <= wd_s;
  end
endmodule

module mips_memory #(
  parameter int SIZE = 32
) (
  input  logic        clock,
  input  logic        we_s,
  input  logic [31:0] addr_s,
  input  logic [31:0] wd_s,
  output logic [31:0] rd_s
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [31:0]   data [0:SIZE-1];
  logic [AW-1:0] idx_s;

  // Byte address, word granular, wrapping over the array depth
  assign idx_s = AW'((addr_s >> 2) % 32'(SIZE));
  assign rd_s  = data[idx_s];

  // Synchronous write; contents are never cleared by reset
  always_ff @(posedge clock) begin
    if (we_s) data[idx_s] <= wd_s;
  end
endmodule

module mips_cpu #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_MEM_SIZE  = 32
) (
  input logic clock,
  input logic reset
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LW   = 6'h23,
                         OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25,
                         FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A;

  logic [31:0] pc_r, pc_plus4_s, next_pc_s, branch_target_s;
  logic [31:0] instr_s, rs_val_s, rt_val_s, sext_imm_s, zext_imm_s;
  logic [31:0] mem_addr_s, dmem_rd_s, result_s;
  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s, wa_s;
  logic        reg_we_s, mem_we_s;

  assign opcode_s        = instr_s[31:26];
  assign rs_s            = instr_s[25:21];
  assign rt_s            = instr_s[20:16];
  assign rd_s            = instr_s[15:11];
  assign shamt_s         = instr_s[10:6];
  assign funct_s         = instr_s[5:0];
  assign sext_imm_s      = {{16{instr_s[15]}}, instr_s[15:0]};
  assign zext_imm_s      = {16'h0000, instr_s[15:0]};
  assign pc_plus4_s      = pc_r + 32'd4;
  assign branch_target_s = pc_plus4_s + {sext_imm_s[29:0], 2'b00};
  assign mem_addr_s      = rs_val_s + sext_imm_s;

  mips_memory #(.SIZE(INSTR_MEM_SIZE)) InstructionMemory_0 (
    .clock (clock), .we_s(1'b0), .addr_s(pc_r), .wd_s(32'd0), .rd_s(instr_s)
  );

  // Write enables are gated so nothing architectural changes while in reset
  mips_memory #(.SIZE(DATA_MEM_SIZE)) DataMemory_0 (
    .clock (clock), .we_s(mem_we_s & ~reset), .addr_s(mem_addr_s),
    .wd_s  (rt_val_s), .rd_s(dmem_rd_s)
  );

  mips_registers Registers_0 (
    .clock (clock), .ra1_s(rs_s), .ra2_s(rt_s), .rd1_s(rs_val_s), .rd2_s(rt_val_s),
    .we_s  (reg_we_s & ~reset), .wa_s(wa_s), .wd_s(result_s)
  );

  // Decode and execute; unknown opcode/funct falls through as a NOP
  always_comb begin
    result_s  = 32'd0;
    wa_s      = rt_s;
    reg_we_s  = 1'b0;
    mem_we_s  = 1'b0;
    next_pc_s = pc_plus4_s;
    case (opcode_s)
      OP_RTYPE: begin
        wa_s     = rd_s;
        reg_we_s = 1'b1;
        case (funct_s)
          FN_ADD:  result_s = rs_val_s + rt_val_s;
          FN_SUB:  result_s = rs_val_s - rt_val_s;
          FN_AND:  result_s = rs_val_s & rt_val_s;
          FN_OR:   result_s = rs_val_s | rt_val_s;
          FN_XOR:  result_s = rs_val_s ^ rt_val_s;
          FN_NOR:  result_s = ~(rs_val_s | rt_val_s);
          FN_SLT:  result_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
          FN_SLL:  result_s = rt_val_s << shamt_s;
          FN_SRL:  result_s = rt_val_s >> shamt_s;
          default: reg_we_s = 1'b0;
        endcase
      end
      OP_ADDI: begin reg_we_s = 1'b1; result_s = rs_val_s + sext_imm_s; end
      OP_SLTI: begin
        reg_we_s = 1'b1;
        result_s = {31'd0, $signed(rs_val_s) < $signed(sext_imm_s)};
      end
      OP_ANDI: begin reg_we_s = 1'b1; result_s = rs_val_s & zext_imm_s; end
      OP_ORI:  begin reg_we_s = 1'b1; result_s = rs_val_s | zext_imm_s; end
      OP_LW:   begin reg_we_s = 1'b1; result_s = dmem_rd_s; end
      OP_SW:   mem_we_s = 1'b1;
      OP_BEQ: begin
        if (rs_val_s == rt_val_s) next_pc_s = branch_target_s;
        else next_pc_s = pc_plus4_s;
      end
      OP_BNE: begin
        if (rs_val_s != rt_val_s) next_pc_s = branch_target_s;
        else next_pc_s = pc_plus4_s;
      end
      OP_J:    next_pc_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
      default: next_pc_s = pc_plus4_s;
    endcase
  end

  // Program counter; reset pulls it to word 0 without waiting for an edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_r <= 32'd0;
    else       pc_r <= next_pc_s;
  end
endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed program checks plus a random
// program compared each cycle against an instruction-level model.

module tb_mips_cpu;
  logic clock, reset;
  int   n_checks, n_fail;

  logic [31:0] prog  [0:31];
  logic [31:0] m_imem[0:31];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_dmem[0:31];
  logic [31:0] m_pc;

  mips_cpu #(.INSTR_MEM_SIZE(32), .DATA_MEM_SIZE(32)) dut (.clock(clock), .reset(reset));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic write_prog();
    for (int i = 0; i < 32; i++) begin
      dut.InstructionMemory_0.data[i] = prog[i];
      m_imem[i] = prog[i];
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Instruction-set model: executes the word at m_pc and updates m_* state
  task automatic model_step();
    logic [31:0] ins, a, b, simm, res, addr;
    int op, fn, rs, rt, rd, sh, wreg;
    bit wr;
    ins  = m_imem[(m_pc / 4) % 32];
    op   = int'(ins[31:26]); fn = int'(ins[5:0]);
    rs   = int'(ins[25:21]); rt = int'(ins[20:16]);
    rd   = int'(ins[15:11]); sh = int'(ins[10:6]);
    a    = m_reg[rs]; b = m_reg[rt];
    simm = 32'($signed(ins[15:0]));
    addr = a + simm;
    wr = 1'b0; wreg = rt; res = 32'd0;
    m_pc = m_pc + 32'd4;
    case (op)
      0: begin
        wreg = rd; wr = 1'b1;
        case (fn)
          'h20: res = a + b;
          'h22: res = a - b;
          'h24: res = a & b;
          'h25: res = a | b;
          'h26: res = a ^ b;
          'h27: res = ~(a | b);
          'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          'h00: res = b << sh;
          'h02: res = b >> sh;
          default: wr = 1'b0;
        endcase
      end
      'h08: begin wr = 1'b1; res = a + simm; end
      'h0A: begin wr = 1'b1; res = (int'(a) < int'(simm)) ? 32'd1 : 32'd0; end
      'h0C: begin wr = 1'b1; res = a & {16'h0000, ins[15:0]}; end
      'h0D: begin wr = 1'b1; res = a | {16'h0000, ins[15:0]}; end
      'h23: begin wr = 1'b1; res = m_dmem[(addr / 4) % 32]; end
      'h2B: m_dmem[(addr / 4) % 32] = b;
      'h04: if (a == b) m_pc = m_pc + simm * 4;
      'h05: if (a != b) m_pc = m_pc + simm * 4;
      'h02: m_pc = {m_pc[31:28], ins[25:0], 2'b00};
      default: wr = 1'b0;
    endcase
    if (wr && wreg != 0) m_reg[wreg] = res;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    for (int i = 0; i < 32; i++) begin
      prog[i] = 32'd0;
      dut.Registers_0.data[i] = 32'(i);
      dut.DataMemory_0.data[i] = 32'd0;
    end
    dut.Registers_0.data[3] = 32'hDEAD_BEEF;
    prog[0]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    prog[1]  = enc_r(5'd2, 5'd5, 5'd4, 5'd0, 6'h22);
    prog[2]  = enc_r(5'd5, 5'd2, 5'd6, 5'd0, 6'h2A);
    prog[3]  = enc_r(5'd2, 5'd5, 5'd7, 5'd0, 6'h2A);
    prog[4]  = enc_i(6'h2B, 5'd0, 5'd9, 16'd8);
    prog[5]  = enc_i(6'h23, 5'd0, 5'd10, 16'd8);
    prog[6]  = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    prog[7]  = enc_i(6'h08, 5'd1, 5'd11, 16'hFFFE);
    prog[8]  = enc_i(6'h0D, 5'd0, 5'd12, 16'hFFFF);
    prog[9]  = enc_r(5'd0, 5'd2, 5'd13, 5'd4, 6'h00);
    prog[10] = enc_r(5'd0, 5'd4, 5'd14, 5'd28, 6'h02);
    prog[11] = enc_r(5'd0, 5'd0, 5'd15, 5'd0, 6'h27);
    prog[12] = enc_r(5'd12, 5'd11, 5'd16, 5'd0, 6'h26);
    prog[13] = enc_r(5'd12, 5'd11, 5'd17, 5'd0, 6'h24);
    prog[14] = enc_i(6'h3F, 5'd1, 5'd18, 16'd5);
    prog[15] = enc_r(5'd1, 5'd2, 5'd19, 5'd0, 6'h01);
    prog[16] = enc_i(6'h0A, 5'd4, 5'd20, 16'hFFFF);
    prog[17] = enc_i(6'h0C, 5'd11, 5'd21, 16'h00F0);
    write_prog();
    #1;
    n_checks++;
    if (dut.pc_r !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", dut.pc_r, 32'd0); end
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[3] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL reset_no_write: got %h expected %h", dut.Registers_0.data[3], 32'hDEAD_BEEF);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[3] !== 32'd3) begin n_fail++; $display("FAIL add_r3: got %h expected %h", dut.Registers_0.data[3], 32'd3); end
    n_checks++;
    if (dut.pc_r !== 32'd4) begin n_fail++; $display("FAIL first_pc: got %h expected %h", dut.pc_r, 32'd4); end
  endtask

  task automatic test_alu();
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[4] !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sub_r4: got %h expected %h", dut.Registers_0.data[4], 32'hFFFF_FFFD); end
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[6] !== 32'd0) begin n_fail++; $display("FAIL slt_r6: got %h expected %h", dut.Registers_0.data[6], 32'd0); end
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[7] !== 32'd1) begin n_fail++; $display("FAIL slt_r7: got %h expected %h", dut.Registers_0.data[7], 32'd1); end
  endtask

  task automatic test_mem();
    @(posedge clock); #1;
    n_checks++;
    if (dut.DataMemory_0.data[2] !== 32'd9) begin n_fail++; $display("FAIL sw_dmem2: got %h expected %h", dut.DataMemory_0.data[2], 32'd9); end
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[10] !== 32'd9) begin n_fail++; $display("FAIL lw_r10: got %h expected %h", dut.Registers_0.data[10], 32'd9); end
  endtask

  task automatic test_imm();
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[0] !== 32'd0) begin n_fail++; $display("FAIL r0_zero: got %h expected %h", dut.Registers_0.data[0], 32'd0); end
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[11] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_r11: got %h expected %h", dut.Registers_0.data[11], 32'hFFFF_FFFF); end
    @(posedge clock); #1;
    n_checks++;
    if (dut.Registers_0.data[12] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ori_r12: got %h expected %h", dut.Registers_0.data[12], 32'h0000_FFFF); end
  endtask

  task automatic test_logic_shift();
    logic [31:0] exp_v [0:8];
    int          reg_i [0:8];
    exp_v = '{32'h20, 32'hF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'd18, 32'd19, 32'd1, 32'hF0};
    reg_i = '{13, 14, 15, 16, 17, 18, 19, 20, 21};
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      n_checks++;
      if (dut.Registers_0.data[reg_i[k]] !== exp_v[k]) begin
        n_fail++; $display("FAIL logic_r%0d: got %h expected %h", reg_i[k], dut.Registers_0.data[reg_i[k]], exp_v[k]);
      end
    end
    n_checks++;
    if (dut.pc_r !== 32'd72) begin n_fail++; $display("FAIL pc_after_prog: got %h expected %h", dut.pc_r, 32'd72); end
  endtask

  task automatic test_reset_midrun();
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut.pc_r !== 32'd0) begin n_fail++; $display("FAIL midrun_pc: got %h expected %h", dut.pc_r, 32'd0); end
    n_checks++;
    if (dut.Registers_0.data[4] !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL midrun_regs: got %h expected %h", dut.Registers_0.data[4], 32'hFFFF_FFFD); end
    n_checks++;
    if (dut.DataMemory_0.data[2] !== 32'd9) begin n_fail++; $display("FAIL midrun_dmem: got %h expected %h", dut.DataMemory_0.data[2], 32'd9); end
    dut.Registers_0.data[3] = 32'd0;
    #2;
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (dut.pc_r !== 32'd4) begin n_fail++; $display("FAIL restart_pc: got %h expected %h", dut.pc_r, 32'd4); end
    n_checks++;
    if (dut.Registers_0.data[3] !== 32'd3) begin n_fail++; $display("FAIL restart_r3: got %h expected %h", dut.Registers_0.data[3], 32'd3); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [0:5];
    exp_pc = '{32'd12, 32'd16, 32'd20, 32'd28, 32'd0, 32'd12};
    for (int i = 0; i < 32; i++) prog[i] = 32'd0;
    prog[0] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    prog[3] = enc_i(6'h05, 5'd1, 5'd1, 16'd2);
    prog[4] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    prog[5] = enc_i(6'h05, 5'd1, 5'd2, 16'd1);
    prog[7] = enc_j(26'd0);
    write_prog();
    restart();
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      n_checks++;
      if (dut.pc_r !== exp_pc[k]) begin n_fail++; $display("FAIL branch_pc%0d: got %h expected %h", k, dut.pc_r, exp_pc[k]); end
    end
  endtask

  task automatic test_random();
    int kind;
    logic [4:0] r1, r2, r3;
    logic [5:0] fns [0:9];
    logic [5:0] ops [0:5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h01};
    ops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    for (int i = 0; i < 32; i++) begin
      r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31)); r3 = 5'($urandom_range(0, 31));
      kind = int'($urandom_range(0, 21));
      if (kind < 10)       prog[i] = enc_r(r1, r2, r3, 5'($urandom_range(0, 31)), fns[kind]);
      else if (kind < 16)  prog[i] = enc_i(ops[kind-10], r1, r2, 16'($urandom));
      else if (kind < 18)  prog[i] = enc_i(6'h04, r1, r2, 16'($signed($urandom_range(0, 8)) - 4));
      else if (kind < 20)  prog[i] = enc_i(6'h05, r1, r2, 16'($signed($urandom_range(0, 8)) - 4));
      else if (kind == 20) prog[i] = enc_j(26'($urandom_range(0, 31)));
      else                 prog[i] = enc_i(6'h3F, r1, r2, 16'($urandom));
      m_reg[i]  = (i == 0) ? 32'd0 : ((i < 4) ? 32'(i) : $urandom);
      m_dmem[i] = $urandom;
      dut.Registers_0.data[i]  = m_reg[i];
      dut.DataMemory_0.data[i] = m_dmem[i];
    end
    write_prog();
    m_pc = 32'd0;
    restart();
    for (int c = 0; c < 80; c++) begin
      @(posedge clock); #1;
      model_step();
      n_checks++;
      if (dut.pc_r !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc%0d: got %h expected %h", c, dut.pc_r, m_pc); end
      for (int r = 0; r < 32; r++) begin
        n_checks++;
        if (dut.Registers_0.data[r] !== m_reg[r]) begin
          n_fail++; $display("FAIL rand_reg%0d cyc%0d: got %h expected %h", r, c, dut.Registers_0.data[r], m_reg[r]);
        end
        n_checks++;
        if (dut.DataMemory_0.data[r] !== m_dmem[r]) begin
          n_fail++; $display("FAIL rand_dmem%0d cyc%0d: got %h expected %h", r, c, dut.DataMemory_0.data[r], m_dmem[r]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    test_reset();
    test_alu();
    test_mem();
    test_imm();
    test_logic_shift();
    test_reset_midrun();
    test_branch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
